// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer: captures bit-reversed FFT frames into a ping-pong RAM
// and replays each finished frame in natural bin order as a gap-free burst.
module fft_bitrev_reorder #(
  parameter int N_LOG2 = 10,
  parameter int DW     = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     valid_i,
  input  logic signed [DW-1:0]     re_i,
  input  logic signed [DW-1:0]     im_i,
  output logic                     valid_o,
  output logic signed [DW-1:0]     re_o,
  output logic signed [DW-1:0]     im_o,
  output logic [N_LOG2-1:0]        ctr_o
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  logic [N_LOG2-1:0] r_wr_ctr;
  logic              r_wr_bank;
  logic              r_frame_done;
  logic              r_done_bank;

  state_t            r_state;
  logic [N_LOG2-1:0] r_rd_ctr;
  logic              r_rd_bank;
  logic              r_valid_o;
  logic [N_LOG2-1:0] r_ctr_o;

  logic [2*DW-1:0]   r_mem [0:2*N-1];
  logic [2*DW-1:0]   r_rd_data;

  logic [N_LOG2-1:0] w_wr_ctr_rev;
  logic [N_LOG2:0]   w_wr_addr;
  logic [N_LOG2:0]   w_rd_addr;
  logic              w_wr_en;
  logic              w_rd_en;

  generate
    for (genvar gi = 0; gi < N_LOG2; gi++) begin : g_bitrev
      assign w_wr_ctr_rev[gi] = r_wr_ctr[N_LOG2-1-gi];
    end
  endgenerate

  // Writes are suppressed while reset is held so a stalled source cannot corrupt a bank.
  assign w_wr_en   = valid_i & rst_n_i;
  assign w_wr_addr = {r_wr_bank, w_wr_ctr_rev};
  assign w_rd_en   = (r_state == S_READ);
  assign w_rd_addr = {r_rd_bank, r_rd_ctr};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ctr     <= '0;
      r_wr_bank    <= 1'b0;
      r_frame_done <= 1'b0;
      r_done_bank  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (valid_i) begin
        r_wr_ctr <= r_wr_ctr + 1'b1;
        if (r_wr_ctr == LAST_IDX) begin
          r_wr_bank    <= ~r_wr_bank;
          r_frame_done <= 1'b1;
          r_done_bank  <= r_wr_bank;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= {re_i, im_i};
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_rd_ctr  <= '0;
      r_rd_bank <= 1'b0;
      r_valid_o <= 1'b0;
      r_ctr_o   <= '0;
    end else begin
      r_valid_o <= w_rd_en;
      r_ctr_o   <= r_rd_ctr;
      case (r_state)
        S_IDLE: begin
          r_rd_ctr <= '0;
          if (r_frame_done) begin
            r_rd_bank <= r_done_bank;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (r_rd_ctr == LAST_IDX) begin
            r_rd_ctr <= '0;
            // A frame finishing on the last read chains straight into the next burst.
            if (r_frame_done) begin
              r_rd_bank <= r_done_bank;
              r_state   <= S_READ;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_rd_ctr <= r_rd_ctr + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_ctr <= '0;
        end
      endcase
    end
  end

  // The RAM read register carries no reset, so data is qualified by the valid flag.
  assign valid_o = r_valid_o;
  assign ctr_o   = r_ctr_o;
  assign re_o    = r_valid_o ? r_rd_data[2*DW-1:DW] : '0;
  assign im_o    = r_valid_o ? r_rd_data[DW-1:0]    : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level model with per-cycle output scoreboard
// plus literal spot checks on captured bursts.
module tb_fft_bitrev_reorder;

  localparam int N_LOG2 = 3;
  localparam int DW     = 25;
  localparam int N      = 1 << N_LOG2;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic                 valid_i;
  logic signed [DW-1:0] re_i;
  logic signed [DW-1:0] im_i;
  logic                 valid_o;
  logic signed [DW-1:0] re_o;
  logic signed [DW-1:0] im_o;
  logic [N_LOG2-1:0]    ctr_o;

  always #5 clk_i = ~clk_i;

  fft_bitrev_reorder #(.N_LOG2(N_LOG2), .DW(DW)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .re_i    (re_i),
    .im_i    (im_i),
    .valid_o (valid_o),
    .re_o    (re_o),
    .im_o    (im_o),
    .ctr_o   (ctr_o)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            bin;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] part_re [N];
  logic [DW-1:0] part_im [N];
  int            part_cnt = 0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] obs_re[$];
  logic [DW-1:0] obs_im[$];

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < N_LOG2; b++)
      if (v[b]) r = r | (1 << (N_LOG2 - 1 - b));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Model: a completed frame yields bin n = arrival bitrev(n), due from 2 edges after the last input.
  always @(posedge clk_i) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_n_i) begin
      exp_q.delete();
      part_cnt = 0;
    end else if (valid_i) begin
      part_re[part_cnt] = re_i;
      part_im[part_cnt] = im_i;
      part_cnt++;
      if (part_cnt == N) begin
        for (int n = 0; n < N; n++) begin
          e.due = cyc + 2 + n;
          e.re  = part_re[bitrev(n)];
          e.im  = part_im[bitrev(n)];
          e.bin = n;
          exp_q.push_back(e);
        end
        part_cnt = 0;
      end
    end
  end

  initial begin
    exp_t c;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        c = exp_q.pop_front();
        check("valid_o", {63'd0, valid_o}, 64'd1);
        check("re_o", {39'd0, $unsigned(re_o)}, {39'd0, c.re});
        check("im_o", {39'd0, $unsigned(im_o)}, {39'd0, c.im});
        check("ctr_o", {61'd0, ctr_o}, 64'(c.bin));
      end else begin
        check("idle_valid_o", {63'd0, valid_o}, 64'd0);
      end
      if (valid_o) begin
        obs_re.push_back(re_o);
        obs_im.push_back(im_o);
      end
    end
  end

  task automatic send(input int re, input int im);
    @(negedge clk_i);
    valid_i = 1'b1;
    re_i    = re[DW-1:0];
    im_i    = im[DW-1:0];
  endtask

  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
    re_i    = '0;
    im_i    = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    repeat (3) @(negedge clk_i);
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic lit(input string name, input int idx, input int val);
    logic [DW-1:0] req;
    req = val[DW-1:0];
    if (idx < obs_re.size()) check(name, {39'd0, obs_re[idx]}, {39'd0, req});
    else check(name, 64'(obs_re.size()), 64'(idx + 1));
  endtask

  initial begin
    int seq[8];
    bit found;
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    re_i    = '0;
    im_i    = '0;
    repeat (3) @(negedge clk_i);
    check("rst_valid_o", {63'd0, valid_o}, 64'd0);
    check("rst_re_o", {39'd0, $unsigned(re_o)}, 64'd0);
    check("rst_im_o", {39'd0, $unsigned(im_o)}, 64'd0);
    check("rst_ctr_o", {61'd0, ctr_o}, 64'd0);
    rst_n_i = 1'b1;

    // Single frame
    obs_re.delete(); obs_im.delete();
    for (int k = 0; k < N; k++) send(k, -k);
    idle();
    drain();
    check("t1_count", 64'(obs_re.size()), 64'd8);
    for (int i = 0; i < N; i++) lit("t1_re_lit", i, seq[i]);
    if (obs_im.size() > 1) check("t1_im_lit", {39'd0, obs_im[1]}, {39'd0, 25'h1FFFFFC});
    $display("frame single: %0d outputs", obs_re.size());

    // Gapped input
    obs_re.delete(); obs_im.delete();
    for (int k = 0; k < N; k++) begin
      send(k, -k);
      idle();
    end
    drain();
    check("t2_count", 64'(obs_re.size()), 64'd8);
    lit("t2_re_lit3", 3, 6);
    $display("frame gapped: %0d outputs", obs_re.size());

    // Continuous stream of three frames
    obs_re.delete(); obs_im.delete();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) send(8*f + k, -(8*f + k));
    idle();
    drain();
    check("t3_count", 64'(obs_re.size()), 64'd24);
    lit("t3_re_lit9", 9, 12);
    lit("t3_re_lit23", 23, 23);
    $display("stream 3 frames: %0d outputs", obs_re.size());

    // Mid-frame reset
    obs_re.delete(); obs_im.delete();
    for (int k = 0; k < 5; k++) send(50 + k, 0);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check("t4_rst_valid_o", {63'd0, valid_o}, 64'd0);
    check("t4_rst_re_o", {39'd0, $unsigned(re_o)}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < N; k++) send(100 + k, -(100 + k));
    idle();
    drain();
    check("t4_count", 64'(obs_re.size()), 64'd8);
    lit("t4_re_lit0", 0, 100);
    lit("t4_re_lit1", 1, 104);
    lit("t4_re_lit7", 7, 107);
    $display("mid-frame reset: %0d outputs", obs_re.size());

    // Reset during READ at ctr_o = 3
    obs_re.delete(); obs_im.delete();
    for (int k = 0; k < N; k++) send(200 + k, 0);
    idle();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_i);
      if (valid_o && ctr_o == 3'd3) found = 1'b1;
    end
    check("t5_ctr3_seen", {63'd0, found}, 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("t5_rst_valid_o", {63'd0, valid_o}, 64'd0);
    check("t5_rst_re_o", {39'd0, $unsigned(re_o)}, 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (12) @(negedge clk_i);
    check("t5_truncated", 64'(obs_re.size()), 64'd4);
    for (int k = 0; k < N; k++) send(300 + k, 0);
    idle();
    drain();
    check("t5_count", 64'(obs_re.size()), 64'd12);
    lit("t5_re_lit4", 4, 300);
    $display("reset during read: %0d outputs", obs_re.size());

    // Extreme values
    obs_re.delete(); obs_im.delete();
    for (int k = 0; k < N; k++) begin
      if (k % 2 == 0) send(-16777216, 16777215);
      else send(16777215, -16777216);
    end
    idle();
    drain();
    lit("t6_re_lit0", 0, -16777216);
    lit("t6_re_lit7", 7, 16777215);
    if (obs_im.size() > 0) check("t6_im_lit0", {39'd0, obs_im[0]}, {39'd0, 25'h0FFFFFF});
    $display("extreme values: %0d outputs", obs_re.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
